// File: rtl/svpwm_pkg.sv
// Shared definitions for the space-vector modulator timing path.
package svpwm_pkg;

  localparam int         PERIOD_DEFAULT    = 2500;
  localparam int         CNT_WIDTH_DEFAULT = 12;
  localparam logic [2:0] SECTOR_MAX        = 3'd5;

  // LOAD first, then the seven segments in centre-aligned order.
  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    S_U0A = 3'd1,
    S_U1A = 3'd2,
    S_U2A = 3'd3,
    S_U7  = 3'd4,
    S_U2B = 3'd5,
    S_U1B = 3'd6,
    S_U0B = 3'd7
  } seg_state_e;

endpackage

// File: rtl/svpwm_phase_sequencer_if.sv
// Request/phase-strobe bundle between the vector source, the sequencer and
// the switch-control stage.
interface svpwm_phase_sequencer_if
  import svpwm_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
);

  logic                 VALID;
  logic [2:0]           SECTOR_IN;
  logic [CNT_WIDTH-1:0] T1;
  logic [CNT_WIDTH-1:0] T2;
  logic [2:0]           SECTOR;
  logic                 U_0;
  logic                 U_1;
  logic                 U_2;
  logic                 U_7;
  logic                 PERIOD_START;
  logic                 OVM;
  logic                 ERR;

  modport master (
    output VALID, SECTOR_IN, T1, T2,
    input  SECTOR, U_0, U_1, U_2, U_7, PERIOD_START, OVM, ERR
  );

  modport slave (
    input  VALID, SECTOR_IN, T1, T2,
    output SECTOR, U_0, U_1, U_2, U_7, PERIOD_START, OVM, ERR
  );

endinterface

// File: rtl/svpwm_dwell_calc.sv
// Half-period dwell split: clamps T1/T2 to the period and divides the
// remaining time between the outer zero vectors and the centre zero vector.
module svpwm_dwell_calc
  import svpwm_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT,
  parameter int PERIOD    = PERIOD_DEFAULT
) (
  input  logic [CNT_WIDTH-1:0] t1_i,
  input  logic [CNT_WIDTH-1:0] t2_i,
  output logic [CNT_WIDTH-1:0] h0a_o,
  output logic [CNT_WIDTH-1:0] h1_o,
  output logic [CNT_WIDTH-1:0] h2_o,
  output logic [CNT_WIDTH-1:0] h0b_o,
  output logic                 ovm_o
);

  localparam logic [CNT_WIDTH-1:0] PERIOD_C = CNT_WIDTH'(PERIOD);
  localparam logic [CNT_WIDTH-1:0] HALF_C   = CNT_WIDTH'(PERIOD / 2);

  logic [CNT_WIDTH-1:0] t1c, t2c, rem, h0;
  logic [CNT_WIDTH:0]   sum;

  // Clamp, halve and distribute; odd LSBs dropped from h1/h2 land in h0.
  // NOTE: every combinational output gets a value on every path, so no latch is inferred.
  always_comb begin
    t1c   = (t1_i > PERIOD_C) ? PERIOD_C : t1_i;
    rem   = PERIOD_C - t1c;
    t2c   = (t2_i > rem) ? rem : t2_i;
    sum   = {1'b0, t1_i} + {1'b0, t2_i};
    ovm_o = (sum > {1'b0, PERIOD_C});
    h1_o  = t1c >> 1;
    h2_o  = t2c >> 1;
    h0    = HALF_C - h1_o - h2_o;
    h0a_o = h0 >> 1;
    h0b_o = h0 - h0a_o;
  end

endmodule

// File: rtl/svpwm_phase_sequencer.sv
// Seven-segment centre-aligned phase sequencer with double-buffered vectors.
module svpwm_phase_sequencer
  import svpwm_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT,
  parameter int PERIOD    = PERIOD_DEFAULT
) (
  input  logic                      CLK,
  input  logic                      RESET,
  svpwm_phase_sequencer_if.slave    bus
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  seg_state_e           state_q, state_d, cand;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cand_len;
  logic                 load, found;

  logic [2:0]           pend_sector_q;
  logic [CNT_WIDTH-1:0] pend_t1_q, pend_t2_q;

  logic [CNT_WIDTH-1:0] h0a_q, h1_q, h2_q, h0b_q;
  logic [CNT_WIDTH-1:0] calc_h0a, calc_h1, calc_h2, calc_h0b;
  logic                 calc_ovm;

  logic [2:0]           sector_q;
  logic                 ovm_q, period_start_q, err_q;
  logic                 u0_q, u1_q, u2_q, u7_q;

  svpwm_dwell_calc #(.CNT_WIDTH(CNT_WIDTH), .PERIOD(PERIOD)) u_dwell (
    .t1_i  (pend_t1_q),
    .t2_i  (pend_t2_q),
    .h0a_o (calc_h0a),
    .h1_o  (calc_h1),
    .h2_o  (calc_h2),
    .h0b_o (calc_h0b),
    .ovm_o (calc_ovm)
  );

  // Length of a segment given one period's set of half-dwells.
  function automatic logic [CNT_WIDTH-1:0] seg_len(
    input seg_state_e s,
    input logic [CNT_WIDTH-1:0] a, b, c, d
  );
    case (s)
      S_U0A, S_U0B: return a;
      S_U1A, S_U1B: return b;
      S_U2A, S_U2B: return c;
      S_U7:         return {d[CNT_WIDTH-2:0], 1'b0};
      default:      return '0;
    endcase
  endfunction

  // Next-state: count down, else jump to the next nonzero segment; running
  // off the end (or leaving LOAD) restarts from the freshly computed dwells.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    found    = 1'b0;
    cand     = LOAD;
    cand_len = '0;
    if (state_q != LOAD && cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end else begin
      if (state_q != LOAD) begin
        for (int i = 1; i < 8; i++) begin
          cand     = seg_state_e'(3'(i));
          cand_len = seg_len(cand, h0a_q, h1_q, h2_q, h0b_q);
          if (!found && cand > state_q && cand_len != '0) begin
            state_d = cand;
            cnt_d   = cand_len - ONE;
            found   = 1'b1;
          end
        end
      end
      if (!found) begin
        load = 1'b1;
        for (int i = 1; i < 8; i++) begin
          cand     = seg_state_e'(3'(i));
          cand_len = seg_len(cand, calc_h0a, calc_h1, calc_h2, calc_h0b);
          if (!found && cand_len != '0) begin
            state_d = cand;
            cnt_d   = cand_len - ONE;
            found   = 1'b1;
          end
        end
      end
    end
  end

  // Segment state and dwell counter.
  // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pending (shadow) vector capture; out-of-range sectors are rejected.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pend_sector_q <= '0;
      pend_t1_q     <= '0;
      pend_t2_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      err_q <= bus.VALID && (bus.SECTOR_IN > SECTOR_MAX);
      if (bus.VALID && (bus.SECTOR_IN <= SECTOR_MAX)) begin
        pend_sector_q <= bus.SECTOR_IN;
        pend_t1_q     <= bus.T1;
        pend_t2_q     <= bus.T2;
      end
    end
  end

  // Active period registers and registered one-hot phase strobes.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sector_q       <= '0;
      ovm_q          <= 1'b0;
      h0a_q          <= '0;
      h1_q           <= '0;
      h2_q           <= '0;
      h0b_q          <= '0;
      period_start_q <= 1'b0;
      u0_q           <= 1'b0;
      u1_q           <= 1'b0;
      u2_q           <= 1'b0;
      u7_q           <= 1'b0;
    end else begin
      if (load) begin
        sector_q <= pend_sector_q;
        ovm_q    <= calc_ovm;
        h0a_q    <= calc_h0a;
        h1_q     <= calc_h1;
        h2_q     <= calc_h2;
        h0b_q    <= calc_h0b;
      end
      period_start_q <= load;
      u0_q           <= (state_d == S_U0A) || (state_d == S_U0B);
      u1_q           <= (state_d == S_U1A) || (state_d == S_U1B);
      u2_q           <= (state_d == S_U2A) || (state_d == S_U2B);
      u7_q           <= (state_d == S_U7);
    end
  end

  assign bus.SECTOR       = sector_q;
  assign bus.OVM          = ovm_q;
  assign bus.PERIOD_START = period_start_q;
  assign bus.ERR          = err_q;
  assign bus.U_0          = u0_q;
  assign bus.U_1          = u1_q;
  assign bus.U_2          = u2_q;
  assign bus.U_7          = u7_q;

endmodule

// File: tb/tb_svpwm_phase_sequencer.sv
// Scoreboard bench: stimulus queues the expected run-length shape of each
// period, a monitor records what the DUT emits and compares per period.
module tb_svpwm_phase_sequencer;
  import svpwm_pkg::*;

  localparam int CW  = 12;
  localparam int PER = 100;

  // Expected period: sector, OVM flag and up to seven runs of {phase, length}
  // where phase 0=U_0, 1=U_1, 2=U_2, 3=U_7.
  typedef struct packed {
    logic [2:0]       sector;
    logic             ovm;
    logic [2:0]       n;
    logic [6:0][13:0] run;
  } exp_t;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;

  svpwm_phase_sequencer_if #(.CNT_WIDTH(CW)) bus ();

  svpwm_phase_sequencer #(.CNT_WIDTH(CW), .PERIOD(PER)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  int   checks       = 0;
  int   errors       = 0;
  int   err_seen     = 0;
  int   periods_done = 0;
  exp_t exp_q[$];

  localparam logic [13:0] Z = 14'd0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  function automatic logic [13:0] rl(input int ph, input int len);
    return {2'(ph), 12'(len)};
  endfunction

  function automatic exp_t mk(input int s, input int o, input int n,
                              input logic [13:0] r0, r1, r2, r3, r4, r5, r6);
    exp_t e;
    e.sector = 3'(s);
    e.ovm    = 1'(o);
    e.n      = 3'(n);
    e.run    = {r6, r5, r4, r3, r2, r1, r0};
    return e;
  endfunction

  // ---------------- monitor ----------------
  exp_t cur;
  bit   have_exp   = 0;
  bit   in_period  = 0;
  int   cycles     = 0;
  int   bad_onehot = 0;
  int   bad_stable = 0;
  logic [2:0] per_sector;
  logic       per_ovm;
  int   act_n = 0;
  int   act_ph [16];
  int   act_len[16];

  task automatic close_period();
    check("period_len", cycles, PER);
    check("onehot_violations", bad_onehot, 0);
    check("sector_ovm_changes", bad_stable, 0);
    if (have_exp) begin
      check("run_count", act_n, int'(cur.n));
      for (int i = 0; i < int'(cur.n) && i < act_n; i++)
        check($sformatf("run%0d_phase_len", i), act_ph[i] * 4096 + act_len[i], int'(cur.run[i]));
    end
    periods_done++;
  endtask

  initial begin : monitor
    int ph;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        in_period = 0;
      end else begin
        if (bus.ERR === 1'b1) err_seen++;
        if (bus.PERIOD_START === 1'b1) begin
          if (in_period) close_period();
          if (exp_q.size() == 0) begin
            have_exp = 0;
            checks++;
            errors++;
            $display("FAIL unexpected_period actual=period_start required=no_period");
          end else begin
            have_exp = 1;
            cur = exp_q.pop_front();
            check("period_sector", int'(bus.SECTOR), int'(cur.sector));
            check("period_ovm", int'(bus.OVM), int'(cur.ovm));
          end
          in_period  = 1;
          cycles     = 0;
          bad_onehot = 0;
          bad_stable = 0;
          act_n      = 0;
          per_sector = bus.SECTOR;
          per_ovm    = bus.OVM;
        end
        if (in_period) begin
          cycles++;
          if ($countones({bus.U_0, bus.U_1, bus.U_2, bus.U_7}) != 1) bad_onehot++;
          if (bus.SECTOR !== per_sector || bus.OVM !== per_ovm) bad_stable++;
          ph = bus.U_1 ? 1 : bus.U_2 ? 2 : bus.U_7 ? 3 : 0;
          if (act_n > 0 && act_ph[act_n-1] == ph) act_len[act_n-1]++;
          else if (act_n < 16) begin
            act_ph[act_n]  = ph;
            act_len[act_n] = 1;
            act_n++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ps();
    bit seen;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge CLK);
      seen = (bus.PERIOD_START === 1'b1);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL period_start_timeout actual=none required=pulse_within_300_cycles");
      finish_run();
    end
  endtask

  // Drive VALID during cycle 'cyc' of the current period (called at the
  // negedge of cycle 1); returns at the negedge of cycle cyc+1.
  task automatic send(input int cyc, input int s, input int t1, input int t2);
    repeat (cyc - 1) @(negedge CLK);
    bus.VALID     = 1'b1;
    bus.SECTOR_IN = 3'(s);
    bus.T1        = CW'(t1);
    bus.T2        = CW'(t2);
    @(negedge CLK);
    bus.VALID     = 1'b0;
  endtask

  initial begin : stimulus
    exp_t e0, ea, eb, ec, ed, ef, eg, eh;
    int   e_before;
    e0 = mk(0, 0, 3, rl(0,25), rl(3,50), rl(0,25), Z, Z, Z, Z);
    ea = mk(0, 0, 7, rl(0,10), rl(1,20), rl(2,10), rl(3,20), rl(2,10), rl(1,20), rl(0,10));
    eb = mk(1, 0, 3, rl(0,25), rl(3,50), rl(0,25), Z, Z, Z, Z);
    ec = mk(4, 1, 3, rl(1,40), rl(2,20), rl(1,40), Z, Z, Z, Z);
    ed = mk(3, 0, 7, rl(0,10), rl(1,20), rl(2,10), rl(3,20), rl(2,10), rl(1,20), rl(0,10));
    ef = mk(1, 0, 7, rl(0,5), rl(1,10), rl(2,30), rl(3,10), rl(2,30), rl(1,10), rl(0,5));
    eg = mk(5, 0, 1, rl(1,100), Z, Z, Z, Z, Z, Z);
    eh = mk(2, 0, 7, rl(0,10), rl(1,15), rl(2,15), rl(3,20), rl(2,15), rl(1,15), rl(0,10));

    bus.VALID     = 1'b0;
    bus.SECTOR_IN = '0;
    bus.T1        = '0;
    bus.T2        = '0;
    #2 RESET = 1'b1;
    #1 check("reset_outputs",
             int'({bus.U_0, bus.U_1, bus.U_2, bus.U_7, bus.PERIOD_START, bus.OVM, bus.ERR, bus.SECTOR}), 0);
    exp_q.push_back(e0);
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("load_cycle_idle", int'({bus.U_0, bus.U_1, bus.U_2, bus.U_7, bus.PERIOD_START}), 0);

    wait_ps();  send(10, 0, 40, 20); exp_q.push_back(ea);   // P1 default
    wait_ps();  send(10, 1, 0, 0);   exp_q.push_back(eb);   // P2 A
    wait_ps();  send(10, 4, 80, 60); exp_q.push_back(ec);   // P3 B
    wait_ps();  send(10, 3, 41, 21); exp_q.push_back(ed);   // P4 C

    wait_ps();                                              // P5 D: bad sector
    e_before = err_seen;
    send(20, 6, 80, 60);
    repeat (3) @(negedge CLK);
    check("err_single_pulse", err_seen - e_before, 1);
    exp_q.push_back(ed);

    wait_ps();                                              // P6 D: last one wins
    send(10, 5, 10, 30);
    send(20, 1, 20, 60);
    exp_q.push_back(ef);

    wait_ps();                                              // P7 F: VALID on last cycle
    exp_q.push_back(ef);
    send(PER, 5, 100, 0);                                   // returns in P8 cycle 1
    exp_q.push_back(eg);

    wait_ps();  send(10, 2, 30, 30); exp_q.push_back(eh);   // P9 G

    wait_ps();                                              // P10 H: reset in U_7
    repeat (49) @(negedge CLK);
    check("u7_before_reset", int'(bus.U_7), 1);
    #2 RESET = 1'b1;
    #1 check("async_reset_outputs",
             int'({bus.U_0, bus.U_1, bus.U_2, bus.U_7, bus.PERIOD_START, bus.OVM, bus.ERR, bus.SECTOR}), 0);
    exp_q.delete();
    exp_q.push_back(e0);
    @(posedge CLK);
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("post_reset_idle", int'({bus.U_0, bus.U_1, bus.U_2, bus.U_7, bus.PERIOD_START}), 0);

    wait_ps();  exp_q.push_back(e0);                        // P11 default
    wait_ps();                                              // P12 closes P11
    repeat (3) @(negedge CLK);
    check("periods_compared", periods_done, 10);
    check("err_total", err_seen, 1);
    check("queue_drained", exp_q.size(), 0);
    finish_run();
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/svpwm_phase_sequencer.md
Name: svpwm_phase_sequencer

Overview:
Upstream timing stage of the space-vector modulator. Takes the sector index and active-vector dwell times T1/T2 for one PWM period. Emits a centre-aligned 7-segment sequence U_0, U_1, U_2, U_7, U_2, U_1, U_0 as one-hot phase strobes plus a registered SECTOR, which the switch-control stage maps to S_1..S_3. New vectors are double-buffered and applied only at period boundaries.

Parameters:
CNT_WIDTH, 12, width of dwell inputs and internal counters; must hold PERIOD.
PERIOD, 2500, PWM period in CLK cycles; must be even and ≥ 4.

Ports:
CLK  input  1  system clock, all logic on rising edge
RESET  input  1  asynchronous, active-high reset
VALID  input  1  one-cycle strobe; SECTOR_IN/T1/T2 sampled when high
SECTOR_IN  input  3  requested sector 0..5
T1  input  CNT_WIDTH  dwell of first active vector per period, cycles
T2  input  CNT_WIDTH  dwell of second active vector per period, cycles
SECTOR  output  3  sector of the period in progress, registered
U_0  output  1  zero-vector phase (outer segments)
U_1  output  1  first active-vector phase
U_2  output  1  second active-vector phase
U_7  output  1  zero-vector phase (centre segment)
PERIOD_START  output  1  one-cycle pulse on the first cycle of each period
OVM  output  1  high for a period whose T1+T2 was clamped
ERR  output  1  one-cycle pulse when VALID carries SECTOR_IN ≥ 6

Behaviour:
- Reset (async assert, sync release): U_0..U_7=0, SECTOR=0, PERIOD_START=0, OVM=0, ERR=0. Pending and active registers clear to sector 0, T1=T2=0, FSM=LOAD.
- Pending capture: VALID with SECTOR_IN ≤ 5 updates pending regs on the next edge. VALID with SECTOR_IN ≥ 6 leaves pending unchanged and pulses ERR on the next cycle.
- Repeated VALID within one period: last one wins.
- Dwell calc (combinational from pending), H = PERIOD/2:
  - t1c = min(T1, PERIOD)
  - t2c = min(T2, PERIOD − t1c)
  - OVM_next = (T1+T2 > PERIOD), evaluated at CNT_WIDTH+1 bits
  - h1 = t1c>>1, h2 = t2c>>1, h0 = H − h1 − h2
  - h0a = h0>>1, h0b = h0 − h0a
- FSM states: LOAD, S_U0A, S_U1A, S_U2A, S_U7, S_U2B, S_U1B, S_U0B.
- LOAD is a single internal cycle with no output change:
  - copies pending into the active regs and the computed dwells into segment regs
  - then enters the first segment in order whose length is nonzero
  - LOAD occurs only after reset.
- Segment lengths: U0A=h0a, U1A=h1, U2A=h2, U7=2·h0b, U2B=h2, U1B=h1, U0B=h0a.
- Segments of length 0 are skipped: no cycle is spent and no strobe is emitted.
- Segment counter loads length−1 and decrements. On reaching 0, the FSM advances to the next nonzero segment.
- After the last nonzero segment, the next period starts back-to-back with no idle cycle:
  - shadow load of pending → active happens on the same edge
  - PERIOD_START asserts on the new period's first cycle
- Period length is exactly PERIOD cycles. The lost LSBs of odd T1/T2 go into h0.
- Outputs are registered and one-hot: exactly one of U_0/U_1/U_2/U_7 is high on every cycle after the first period starts.
- SECTOR and OVM change only on PERIOD_START cycles.
- Latency:
  - VALID accepted before the last cycle of a period takes effect at the next PERIOD_START.
  - VALID on the last cycle takes effect one period later.
- Reset mid-period: all outputs drop asynchronously. After release: one LOAD cycle, then a fresh period.

Decomposition:
- Shared package svpwm_pkg holds:
  - segment state enum
  - PERIOD default
  - sector range constant SECTOR_MAX=5
- One sub-module svpwm_dwell_calc (combinational): T1, T2 → h0a, h1, h2, h0b, ovm. Reused by the future over-modulation limiter.

Test Plan:
- PERIOD=100; VALID sector 0, T1=40, T2=20 → next period: U_0 10, U_1 20, U_2 10, U_7 20, U_2 10, U_1 20, U_0 10 cycles. SECTOR=0, OVM=0, PERIOD_START every 100 cycles.
- T1=T2=0 → U_0 25, U_7 50, U_0 25. U_1/U_2 never high.
- T1=80, T2=60 → t2c=20; U_1 40, U_2 20, U_1 40. U_0/U_7 never high; OVM=1 for that period.
- T1=41, T2=21, sector 3 → h1=20, h2=10, h0a=10, h0b=10. SECTOR=3; period still exactly 100 cycles.
- VALID with SECTOR_IN=6 mid-period → ERR pulses once; following period repeats the previous sector/dwells. VALID on last period cycle → applied one period later.
- Assert RESET during S_U7 → all outputs 0 immediately. After release: one idle cycle, then PERIOD_START and U_0 for sector 0, T1=T2=0 (U_0 25 cycles).
